// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point helpers for the neuron datapath: default widths, state
// encoding and sign-magnitude <-> two's complement conversion.
package nn_fixed_pkg;

  localparam int unsigned N_DEF = 32;
  localparam int unsigned Q_DEF = 24;
  // Working width of the conversion helpers; callers cast in and out of it.
  localparam int unsigned MAXW  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic            ovr;
    logic [MAXW-1:0] sm;
  } sat_t;

  // n-bit sign-magnitude to two's complement; -0 becomes 0.
  function automatic logic signed [MAXW-1:0] sm_to_tc(input logic [MAXW-1:0] sm,
                                                       input int unsigned n);
    logic [MAXW-1:0] mag;
    mag = sm & ((MAXW'(1) << (n - 1)) - MAXW'(1));
    return sm[n-1] ? -$signed(mag) : $signed(mag);
  endfunction

  // Two's complement to n-bit sign-magnitude, clamped to +/-(2^(n-1)-1).
  function automatic sat_t tc_to_sm_sat(input logic signed [MAXW-1:0] v,
                                        input int unsigned n);
    logic signed [MAXW-1:0] mx;
    logic [MAXW-1:0]        sgn;
    sat_t                   r;
    mx    = $signed((MAXW'(1) << (n - 1)) - MAXW'(1));
    sgn   = MAXW'(1) << (n - 1);
    r.ovr = 1'b0;
    if (v > mx) begin
      r.ovr = 1'b1;
      r.sm  = mx;
    end else if (v < -mx) begin
      r.ovr = 1'b1;
      r.sm  = sgn | mx;
    end else if (v < 0) begin
      r.sm  = sgn | (-v);
    end else begin
      r.sm  = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/qmult.sv
// Combinational sign-magnitude fixed-point multiplier: full-precision product
// plus a flag when the Q-rescaled magnitude no longer fits in N-1 bits.
module qmult
  import nn_fixed_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned Q = Q_DEF
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p,
  output logic           ovr
);

  localparam int unsigned MW = 2 * N - 2;

  logic [MW-1:0] mag;

  assign mag = MW'(a[N-2:0]) * MW'(b[N-2:0]);
  assign p   = {a[N-1] ^ b[N-1], 1'b0, mag};
  assign ovr = (mag >> Q) > MW'({(N - 1){1'b1}});

endmodule

// File: rtl/mac_sequencer.sv
// Drives the shared qmult through a stream of (input, weight) pairs and
// accumulates the rescaled products plus bias into one saturated result.
module mac_sequencer
  import nn_fixed_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned Q     = Q_DEF,
  parameter int unsigned G     = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic [N-1:0]     i_bias,
  input  logic             i_valid,
  input  logic [N-1:0]     i_x,
  input  logic [N-1:0]     i_w,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N-1:0]     o_sum,
  output logic             o_ovr,
  output logic             o_busy
);

  localparam int unsigned AW = N + G;
  localparam int unsigned PW = 2 * N;
  localparam logic [PW-2:0] TERM_MAX = {{(PW - N){1'b0}}, {(N - 1){1'b1}}};

  // The G guard bits only cover 2^G terms, so a longer count could wrap acc.
  if (LEN_W > G) begin : g_len_check
    $error("mac_sequencer: LEN_W (%0d) must not exceed G (%0d)", LEN_W, G);
  end
  if (N + G > MAXW) begin : g_width_check
    $error("mac_sequencer: N+G (%0d) exceeds helper width %0d", N + G, MAXW);
  end

  state_t                state;
  logic [LEN_W-1:0]      cnt;
  logic signed [AW-1:0]  acc;
  logic [PW-1:0]         p_q;
  logic                  p_ovr;
  logic                  p_vld;

  logic [PW-1:0]         prod_c;
  logic                  qovr_c;
  logic                  hs_c;
  logic [PW-2:0]         shr_c;
  logic [N-2:0]          term_mag_c;
  logic signed [AW-1:0]  term_c;
  logic signed [AW-1:0]  acc_sum_c;
  logic signed [AW-1:0]  bias_c;
  sat_t                  sat_c;
  sat_t                  bias_sat_c;
  logic                  unused_bits_c;

  qmult #(.N(N), .Q(Q)) u_qmult (
    .a   (i_x),
    .b   (i_w),
    .p   (prod_c),
    .ovr (qovr_c)
  );

  // Rescale the registered product, clamp, sign it, and form the next sum.
  always_comb begin
    hs_c       = i_valid & o_ready;
    shr_c      = p_q[PW-2:0] >> Q;
    term_mag_c = (p_ovr || (shr_c > TERM_MAX)) ? {(N - 1){1'b1}} : shr_c[N-2:0];
    if (p_q[PW-1] && (term_mag_c != '0)) begin
      term_c = -$signed(AW'(term_mag_c));
    end else begin
      term_c = $signed(AW'(term_mag_c));
    end
    acc_sum_c     = acc + term_c;
    sat_c         = tc_to_sm_sat(MAXW'(acc_sum_c), N);
    bias_c        = AW'(sm_to_tc(MAXW'(i_bias), N));
    bias_sat_c    = tc_to_sm_sat(MAXW'(bias_c), N);
    unused_bits_c = ^{sat_c.sm[MAXW-1:N], bias_sat_c.sm[MAXW-1:N]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      p_q     <= '0;
      p_ovr   <= 1'b0;
      p_vld   <= 1'b0;
      o_ready <= 1'b0;
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_ovr   <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            acc    <= bias_c;
            cnt    <= i_len;
            p_vld  <= 1'b0;
            o_ovr  <= 1'b0;
            o_busy <= 1'b1;
            if (i_len == '0) begin
              o_sum   <= bias_sat_c.sm[N-1:0];
              o_ovr   <= bias_sat_c.ovr;
              o_valid <= 1'b1;
              state   <= DONE;
            end else begin
              o_ready <= 1'b1;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          p_vld <= hs_c;
          if (hs_c) begin
            p_q     <= prod_c;
            p_ovr   <= qovr_c;
            cnt     <= cnt - LEN_W'(1);
            o_ready <= (cnt != LEN_W'(1));
          end
          // cnt reaching zero with a product pending means this is the last term.
          if (p_vld) begin
            acc   <= acc_sum_c;
            o_ovr <= o_ovr | p_ovr;
            if (cnt == '0) begin
              o_sum   <= sat_c.sm[N-1:0];
              o_ovr   <= o_ovr | p_ovr | sat_c.ovr;
              o_valid <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer at N=8, Q=5 (1.0 = 0x20).
module tb_mac_sequencer;

  logic       clk;
  logic       rst;
  logic       i_start;
  logic [7:0] i_len;
  logic [7:0] i_bias;
  logic       i_valid;
  logic [7:0] i_x;
  logic [7:0] i_w;
  logic       o_ready;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_sum;
  logic       o_ovr;
  logic       o_busy;

  int vectors;
  int miscompares;
  logic [8:0] exp_q[$];

  mac_sequencer #(.N(8), .Q(5), .G(8), .LEN_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_len   (i_len),
    .i_bias  (i_bias),
    .i_valid (i_valid),
    .i_x     (i_x),
    .i_w     (i_w),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_ovr   (o_ovr),
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: integer arithmetic, result packed as {ovr, sum}.
  function automatic logic [8:0] model_op(int len, logic [7:0] bias,
                                          logic [7:0] xs[4], logic [7:0] ws[4]);
    int acc, sh;
    bit ovr;
    logic [7:0] res;
    ovr = 1'b0;
    acc = int'(bias[6:0]);
    if (bias[7]) acc = -acc;
    for (int i = 0; i < len; i++) begin
      sh = (int'(xs[i][6:0]) * int'(ws[i][6:0])) >> 5;
      if (sh > 127) begin
        sh  = 127;
        ovr = 1'b1;
      end
      if (xs[i][7] ^ ws[i][7]) acc = acc - sh;
      else acc = acc + sh;
    end
    if (acc > 127) begin
      res = 8'h7F; ovr = 1'b1;
    end else if (acc < -127) begin
      res = 8'hFF; ovr = 1'b1;
    end else if (acc < 0) begin
      res = {1'b1, 7'(-acc)};
    end else begin
      res = 8'(acc);
    end
    return {ovr, res};
  endfunction

  task automatic start_op(input int len, input logic [7:0] bias,
                          input logic [7:0] xs[4], input logic [7:0] ws[4]);
    exp_q.push_back(model_op(len, bias, xs, ws));
    i_start = 1'b1;
    i_len   = 8'(len);
    i_bias  = bias;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [7:0] xs[4], input logic [7:0] ws[4],
                      input bit rnd, output bit ok);
    int idx;
    int cyc;
    bit hs;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 200) begin
      i_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_x     = xs[idx];
      i_w     = ws[idx];
      hs      = i_valid && o_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    i_valid = 1'b0;
    ok = (idx == n);
  endtask

  task automatic wait_valid(output bit got);
    for (int c = 0; c < 50 && !o_valid; c++) begin
      @(posedge clk); #1;
    end
    got = o_valid;
  endtask

  // Waits for a result, samples it, pops the expectation and releases it.
  task automatic collect(output bit got, output logic [7:0] sum, output logic ovr,
                         output logic [8:0] exp);
    wait_valid(got);
    sum = o_sum;
    ovr = o_ovr;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({o_ready, o_valid, o_sum, o_ovr, o_busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b sum=%h ovr=%b busy=%b, want all 0",
               o_ready, o_valid, o_sum, o_ovr, o_busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [7:0] xs[4] = '{8'h0C, 8'h00, 8'h00, 8'h00};
    logic [7:0] ws[4] = '{8'h05, 8'h00, 8'h00, 8'h00};
    logic [8:0] exp;
    bit ok;
    start_op(1, 8'h00, xs, ws);
    vectors++;
    if (o_busy !== 1'b1 || o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single_run_state: busy=%b ready=%b, want 1 1", o_busy, o_ready);
    end
    feed(1, xs, ws, 1'b0, ok);
    vectors++;
    if (!ok || o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_latency1: handshake=%b valid=%b after 1 edge, want 1 0", ok, o_valid);
    end
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    vectors++;
    if (o_valid !== 1'b1 || {o_ovr, o_sum} !== exp) begin
      miscompares++;
      $display("FAIL single_result: valid=%b ovr=%b sum=%h, want 1 %b %h",
               o_valid, o_ovr, o_sum, exp[8], exp[7:0]);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_release: valid=%b busy=%b, want 0 0", o_valid, o_busy);
    end
  endtask

  task automatic test_multi;
    logic [7:0] xs[4] = '{8'h20, 8'h20, 8'hA0, 8'h00};
    logic [7:0] ws[4] = '{8'h20, 8'h20, 8'h20, 8'h00};
    logic [7:0] xn[4] = '{8'hA0, 8'h00, 8'h00, 8'h00};
    logic [7:0] sum;
    logic ovr;
    logic [8:0] exp;
    bit ok, got;
    start_op(3, 8'h00, xs, ws);
    feed(3, xs, ws, 1'b0, ok);
    collect(got, sum, ovr, exp);
    vectors++;
    if (!ok || !got || {ovr, sum} !== exp) begin
      miscompares++;
      $display("FAIL multi_sum: ok=%b got=%b ovr=%b sum=%h, want ovr=%b sum=%h",
               ok, got, ovr, sum, exp[8], exp[7:0]);
    end
    start_op(1, 8'h00, xn, ws);
    feed(1, xn, ws, 1'b0, ok);
    collect(got, sum, ovr, exp);
    vectors++;
    if (!ok || !got || {ovr, sum} !== exp) begin
      miscompares++;
      $display("FAIL negative_single: got=%b ovr=%b sum=%h, want ovr=%b sum=%h",
               got, ovr, sum, exp[8], exp[7:0]);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] xs[4] = '{8'h7F, 8'h7F, 8'h00, 8'h00};
    logic [7:0] ws[4] = '{8'h7F, 8'h7F, 8'h00, 8'h00};
    logic [7:0] wn[4] = '{8'h7F, 8'hFF, 8'h00, 8'h00};
    logic [7:0] sum;
    logic ovr;
    logic [8:0] exp;
    bit ok, got;
    start_op(2, 8'h00, xs, ws);
    feed(2, xs, ws, 1'b0, ok);
    collect(got, sum, ovr, exp);
    vectors++;
    if (!got || {ovr, sum} !== exp) begin
      miscompares++;
      $display("FAIL ovf_saturate: ovr=%b sum=%h, want ovr=%b sum=%h", ovr, sum, exp[8], exp[7:0]);
    end
    start_op(2, 8'h00, xs, wn);
    feed(2, xs, wn, 1'b0, ok);
    collect(got, sum, ovr, exp);
    vectors++;
    if (!got || {ovr, sum} !== exp) begin
      miscompares++;
      $display("FAIL ovf_cancel: ovr=%b sum=%h, want ovr=%b sum=%h", ovr, sum, exp[8], exp[7:0]);
    end
  endtask

  task automatic test_len_zero;
    logic [7:0] z[4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] sum;
    logic ovr;
    logic [8:0] exp;
    bit got;
    start_op(0, 8'h85, z, z);
    vectors++;
    if (o_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL len0_latency: valid=%b one edge after start, want 1", o_valid);
    end
    collect(got, sum, ovr, exp);
    vectors++;
    if ({ovr, sum} !== exp) begin
      miscompares++;
      $display("FAIL len0_bias: ovr=%b sum=%h, want ovr=%b sum=%h", ovr, sum, exp[8], exp[7:0]);
    end
    start_op(0, 8'h80, z, z);
    collect(got, sum, ovr, exp);
    vectors++;
    if (!got || {ovr, sum} !== exp) begin
      miscompares++;
      $display("FAIL len0_negzero: ovr=%b sum=%h, want ovr=%b sum=%h", ovr, sum, exp[8], exp[7:0]);
    end
  endtask

  task automatic test_back_to_back_stall;
    logic [7:0] xs[4] = '{8'h30, 8'h90, 8'h10, 8'h85};
    logic [7:0] ws[4] = '{8'h28, 8'h20, 8'h10, 8'h46};
    logic [8:0] exp;
    bit ok, got;
    int unstable, extra;
    start_op(4, 8'h02, xs, ws);
    feed(4, xs, ws, 1'b1, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL stall_feed: not all 4 pairs accepted, got %b want 1", ok);
    end
    wait_valid(got);
    exp = exp_q.pop_front();
    vectors++;
    if (!got || {o_ovr, o_sum} !== exp) begin
      miscompares++;
      $display("FAIL stall_sum: got=%b ovr=%b sum=%h, want ovr=%b sum=%h",
               got, o_ovr, o_sum, exp[8], exp[7:0]);
    end
    unstable = 0;
    for (int c = 0; c < 5; c++) begin
      i_start = (c == 2);
      i_len   = 8'd0;
      i_bias  = 8'h11;
      @(posedge clk); #1;
      if (o_valid !== 1'b1 || {o_ovr, o_sum} !== exp) unstable++;
    end
    vectors++;
    if (unstable != 0) begin
      miscompares++;
      $display("FAIL stall_hold: %0d unstable cycles, want 0", unstable);
    end
    i_ready = 1'b1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    i_start = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_start_ignored: valid=%b busy=%b, want 0 0", o_valid, o_busy);
    end
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (o_valid) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL single_result_only: %0d extra valid cycles, want 0", extra);
    end
  endtask

  task automatic test_abort_reset;
    logic [7:0] xs[4] = '{8'h20, 8'h20, 8'h20, 8'h20};
    logic [7:0] ws[4] = '{8'h20, 8'h20, 8'h20, 8'h20};
    logic [7:0] sum;
    logic ovr;
    logic [8:0] exp;
    bit ok, got;
    int extra;
    start_op(4, 8'h10, xs, ws);
    feed(2, xs, ws, 1'b0, ok);
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({o_ready, o_valid, o_sum, o_ovr, o_busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL abort_outputs: rdy=%b vld=%b sum=%h ovr=%b busy=%b, want all 0",
               o_ready, o_valid, o_sum, o_ovr, o_busy);
    end
    rst = 1'b0;
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (o_valid || o_busy) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL abort_no_result: %0d active cycles after abort, want 0", extra);
    end
    start_op(1, 8'h00, xs, ws);
    feed(1, xs, ws, 1'b0, ok);
    collect(got, sum, ovr, exp);
    vectors++;
    if (!got || {ovr, sum} !== exp) begin
      miscompares++;
      $display("FAIL abort_fresh_run: got=%b ovr=%b sum=%h, want ovr=%b sum=%h",
               got, ovr, sum, exp[8], exp[7:0]);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    i_start = 1'b0;
    i_len   = '0;
    i_bias  = '0;
    i_valid = 1'b0;
    i_x     = '0;
    i_w     = '0;
    i_ready = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_overflow();
    test_len_zero();
    test_back_to_back_stall();
    test_abort_reset();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d results outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Sequences one shared sign-magnitude fixed-point multiplier, `qmult`, through a stream of (input, weight) pairs and accumulates the products plus a bias into one neuron pre-activation value.
- Sits between the neuron input/weight buffers and the activation (CORDIC) stage of the neuron datapath.
- A `start` pulse begins a dot product of programmable length; one saturated sign-magnitude result is returned over a valid/ready handshake.

Parameters:
- N, 32, word width; sign-magnitude: bit N-1 is the sign, N-2:0 the magnitude.
- Q, 24, number of fraction bits in every operand and in the result.
- G, 8, accumulator guard bits; the accumulator is N+G bits, two's complement.
- LEN_W, 8, width of the pair-count input.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_len  in  LEN_W  number of pairs; sampled with i_start.
- i_bias  in  N  sign-magnitude bias; sampled with i_start.
- i_valid  in  1  an input/weight pair is present.
- i_x  in  N  input operand, sign-magnitude.
- i_w  in  N  weight operand, sign-magnitude.
- o_ready  out  1  pair accepted when i_valid & o_ready.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts the result.
- o_sum  out  N  saturated sign-magnitude result.
- o_ovr  out  1  sticky overflow for this operation.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: o_ready=0, o_valid=0, o_sum=0, o_ovr=0, o_busy=0. State=IDLE; accumulator, counter and product-valid flag cleared.
- Reset mid-operation aborts immediately. The in-flight product is discarded and no result is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - i_start=1 latches the length and loads acc = sext(tc(i_bias)); o_ovr cleared.
  - If i_len=0, go to DONE next edge with o_sum = sat(acc).
  - Otherwise go to RUN.
- RUN:
  - o_ready = 1 while remaining count > 0.
  - On each handshake: qmult output is registered into p_q together with p_vld=1, and the count is decremented.
  - Next edge: acc += term(p_q). Any qmult ovr sets o_ovr.
  - Accumulation continues while i_valid is low; no pair is lost or duplicated under any i_valid pattern.
  - Leave RUN on the edge that accumulates the last product. That edge registers o_sum = sat(acc + term), sets o_valid=1 and enters DONE.
  - Latency from the last handshake to o_valid high: 2 edges.
- DONE:
  - o_valid, o_sum and o_ovr are held stable until i_ready=1.
  - On that edge: o_valid=0, go to IDLE.
  - An i_start on the same edge is ignored; a new start is accepted only in IDLE.
- term(p): shift the 2N-bit product magnitude right by Q (truncate toward zero). Clamp to 2^(N-1)-1 if qmult ovr=1 or the shifted value exceeds that. Negate if the sign bit is set. A magnitude of 0 gives +0.
- tc(): sign-magnitude to two's complement; -0 maps to 0.
- sat():
  - Clamp acc to ±(2^(N-1)-1) and convert back to sign-magnitude.
  - Clamping sets o_ovr.
  - -0 is never output.
- The accumulator itself never wraps. Each term stays within ±(2^(N-1)-1) and G bits guard up to 2^G terms. LEN_W > G is illegal; flag it in elaboration.

Decomposition:
- Shared package (nn_fixed_pkg):
  - N, Q defaults.
  - sm_to_tc and tc_to_sm_sat functions.
  - State encoding constants.
- One sub-module: the existing `qmult` multiplier, instantiated once as a combinational datapath. All sequencing, rescaling and accumulation stay in mac_sequencer.

Test Plan:
All scenarios use N=8, Q=5 (1.0 = 0x20).
- len=1, bias=0x00, pair (0x0C, 0x05): product 60, shifted result 1 -> o_sum=0x01, o_ovr=0, o_valid 2 edges after the handshake.
- len=3, bias=0x00, pairs (0x20,0x20), (0x20,0x20), (0xA0,0x20) -> o_sum=0x20, o_ovr=0. Also (0xA0,0x20) alone -> 0xA0.
- len=2, pairs (0x7F,0x7F) twice: qmult ovr, each term clamped to 127, sum 254 -> o_sum=0x7F, o_ovr=1. Repeat with one weight 0xFF -> o_sum=0x00, o_ovr=1.
- len=0, i_start with bias=0x85 -> o_valid one edge later, o_sum=0x85. Also bias=0x80 -> o_sum=0x00.
- len=4 with i_valid toggled pseudo-randomly and i_ready held low for 5 cycles -> correct sum, o_sum stable, exactly one result, an i_start during DONE ignored.
- rst pulsed after 2 of 4 pairs -> all outputs 0, IDLE. A fresh len=1 (0x20,0x20) run -> o_sum=0x20.
